// File: rtl/instr_stream_loader_pkg.sv
// Shared constants for the instruction stream loader: FSM encodings, terminator word, byte lanes.
package instr_stream_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_ASSEMBLE = 3'd1;
  localparam state_t S_CHECK    = 3'd2;
  localparam state_t S_WRITE    = 3'd3;
  localparam state_t S_DONE     = 3'd4;

  localparam logic [31:0] END_MARKER_DEF = 32'hFFFF_FFFF;

  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 8;
  localparam int LANE_IDX_W = 2;
  localparam logic [LANE_IDX_W-1:0] LANE_LAST = 2'd3;

endpackage

// File: rtl/instr_stream_loader_byte_packer.sv
// Little-endian 4-byte packer: each accepted byte lands in the lane selected by a wrapping index.
module instr_stream_loader_byte_packer
  import instr_stream_loader_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              accept,
  input  logic [LANE_W-1:0]                 byte_data,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  word,
  output logic                              word_valid
);

  logic [LANE_IDX_W-1:0] idx;

  // word_valid marks the edge that stores the last byte; word is complete the cycle after
  assign word_valid = accept && (idx == LANE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (accept) begin
      word[idx] <= byte_data;
      idx       <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/instr_stream_loader.sv
// Byte-stream to instruction-memory loader; optional checksum word via LOADER_CHECKSUM_EN.
module instr_stream_loader
  import instr_stream_loader_pkg::*;
#(
  parameter int          MAX_WORDS  = 1024,
  parameter logic [31:0] END_MARKER = END_MARKER_DEF,
  parameter int          ADDR_W     = 10
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        start,
  output logic        instr_we,
  output logic [31:0] address,
  output logic [31:0] instruction,
  output logic        load_done,
`ifdef LOADER_CHECKSUM_EN
  output logic        checksum_err,
`endif
  output logic [31:0] word_count
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(MAX_WORDS);

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_nxt;
  logic [31:0]     pword;
  logic            word_valid;
  logic            accept;
  logic            load_go;
  logic            is_end;

  assign byte_ready = (state == S_ASSEMBLE);
  assign accept     = byte_valid && byte_ready;
  assign load_go    = go && (state == S_IDLE || state == S_DONE);
  assign cnt_nxt    = cnt + 1'b1;
  assign word_count = 32'(cnt);

`ifdef LOADER_CHECKSUM_EN
  logic        sum_phase;
  logic [31:0] csum;
  // once the marker is seen, the next word is the checksum, not another terminator
  assign is_end = (pword == END_MARKER) && !sum_phase;
`else
  assign is_end = (pword == END_MARKER);
`endif

  instr_stream_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_go),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (pword),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      start       <= 1'b0;
      instr_we    <= 1'b0;
      address     <= '0;
      instruction <= '0;
      load_done   <= 1'b0;
      cnt         <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_phase    <= 1'b0;
      csum         <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      instr_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state     <= S_ASSEMBLE;
            start     <= 1'b1;
            cnt       <= '0;
            address   <= '0;
            load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_phase    <= 1'b0;
            csum         <= '0;
            checksum_err <= 1'b0;
`endif
          end
        end
        S_ASSEMBLE: begin
          if (word_valid) state <= S_CHECK;
        end
        S_CHECK: begin
          if (is_end) begin
`ifdef LOADER_CHECKSUM_EN
            sum_phase <= 1'b1;
            state     <= S_ASSEMBLE;
`else
            state     <= S_DONE;
            start     <= 1'b0;
            load_done <= 1'b1;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          else if (sum_phase) begin
            checksum_err <= (pword != csum);
            state        <= S_DONE;
            start        <= 1'b0;
            load_done    <= 1'b1;
          end
`endif
          else begin
            state       <= S_WRITE;
            instr_we    <= 1'b1;
            address     <= 32'(cnt[ADDR_W-1:0]);
            instruction <= pword;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ pword;
`endif
          end
        end
        S_WRITE: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == CNT_MAX) begin
            state     <= S_DONE;
            start     <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state <= S_ASSEMBLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader (MAX_WORDS=4); checksum cases when LOADER_CHECKSUM_EN is defined.
module tb_instr_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        start;
  logic        instr_we;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        load_done;
  logic [31:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic        checksum_err;
`endif

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always #5 clk = ~clk;

  instr_stream_loader #(.MAX_WORDS(4), .END_MARKER(32'hFFFF_FFFF), .ADDR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .start       (start),
    .instr_we    (instr_we),
    .address     (address),
    .instruction (instruction),
    .load_done   (load_done),
`ifdef LOADER_CHECKSUM_EN
    .checksum_err(checksum_err),
`endif
    .word_count  (word_count)
  );

  always @(posedge clk) begin
    if (!rst && instr_we) begin
      wr_addr[nwr % 64] <= address;
      wr_data[nwr % 64] <= instruction;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    cyc(1);
    go = 1'b0;
  endtask

  // present a byte after `gap` idle cycles and hold it until it is taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    cyc(gap);
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !byte_ready; i++) cyc(1);
    if (!byte_ready) chk("byte_accept_timeout", {31'd0, byte_ready}, 32'd1);
    cyc(1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  int base;

  initial begin
    rst = 1'b1; go = 1'b0; byte_data = 8'h00; byte_valid = 1'b0;
    cyc(3);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_we", {31'd0, instr_we}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_count", word_count, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // first word; go and byte_valid together: byte must not be taken in IDLE
    byte_valid = 1'b1; byte_data = 8'h13;
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    byte_valid = 1'b0;
    chk("go_start", {31'd0, start}, 32'd1);
    chk("go_ready", {31'd0, byte_ready}, 32'd1);
    base = nwr;
    send_word(32'h0000_0513, 0);
    chk("lat_chk_we", {31'd0, instr_we}, 32'd0);
    chk("lat_chk_ready", {31'd0, byte_ready}, 32'd0);
    cyc(1);
    chk("lat_we", {31'd0, instr_we}, 32'd1);
    chk("lat_addr", address, 32'd0);
    chk("lat_instr", instruction, 32'h0000_0513);
    chk("lat_start", {31'd0, start}, 32'd1);
    cyc(1);
    chk("cnt1", word_count, 32'd1);
    send_word(32'hDDCC_BBAA, 0);
    send_word(32'h0403_0201, 0);
    send_word(32'hFFFF_FFFF, 0);
    cyc(2);
    chk("t2_nwr", nwr - base, 32'd3);
    chk("t2_addr1", wr_addr[(base+1)%64], 32'd1);
    chk("t2_addr2", wr_addr[(base+2)%64], 32'd2);
    chk("t2_data1", wr_data[(base+1)%64], 32'hDDCC_BBAA);
    chk("t2_data2", wr_data[(base+2)%64], 32'h0403_0201);
    chk("t2_start", {31'd0, start}, 32'd0);
    chk("t2_done", {31'd0, load_done}, 32'd1);
    chk("t2_count", word_count, 32'd3);
    chk("t2_ready", {31'd0, byte_ready}, 32'd0);

    // capacity: 4 words fill memory, the rest of the stream must stall
    pulse_go();
    chk("t3_done_clr", {31'd0, load_done}, 32'd0);
    chk("t3_count_clr", word_count, 32'd0);
    base = nwr;
    for (int w = 0; w < 4; w++) send_word(32'h1000_0000 + 32'(w), 0);
    cyc(2);
    byte_data = 8'h55; byte_valid = 1'b1;
    cyc(4);
    chk("t3_nwr", nwr - base, 32'd4);
    chk("t3_addr3", wr_addr[(base+3)%64], 32'd3);
    chk("t3_data3", wr_data[(base+3)%64], 32'h1000_0003);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    chk("t3_done", {31'd0, load_done}, 32'd1);
    chk("t3_count", word_count, 32'd4);
    chk("t3_start", {31'd0, start}, 32'd0);
    byte_valid = 1'b0;

    // gapped stream: partial word survives gaps, no early write
    pulse_go();
    base = nwr;
    send_byte(8'h13, 2);
    send_byte(8'h05, 3);
    cyc(6);
    chk("t4_partial_nwr", nwr - base, 32'd0);
    chk("t4_partial_start", {31'd0, start}, 32'd1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 4);
    cyc(2);
    chk("t4_nwr", nwr - base, 32'd1);
    chk("t4_addr", wr_addr[base%64], 32'd0);
    chk("t4_data", wr_data[base%64], 32'h0000_0513);
    send_word(32'hFFFF_FFFF, 1);
    cyc(2);
    chk("t4_count", word_count, 32'd1);

    // asynchronous reset mid-word
    pulse_go();
    send_word(32'hCAFE_F00D, 0);
    cyc(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_start", {31'd0, start}, 32'd0);
    chk("t5_ready", {31'd0, byte_ready}, 32'd0);
    chk("t5_addr", address, 32'd0);
    chk("t5_instr", instruction, 32'd0);
    chk("t5_count", word_count, 32'd0);
    chk("t5_done", {31'd0, load_done}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    pulse_go();
    base = nwr;
    send_word(32'h1234_5678, 0);
    cyc(2);
    chk("t5_nwr", nwr - base, 32'd1);
    chk("t5_raddr", wr_addr[base%64], 32'd0);
    chk("t5_rdata", wr_data[base%64], 32'h1234_5678);
    send_word(32'hFFFF_FFFF, 0);
    cyc(2);
    chk("t5_rcount", word_count, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    pulse_go();
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'hFFFF_FFFF, 0);
    cyc(2);
    chk("cs_wait_done", {31'd0, load_done}, 32'd0);
    send_word(32'd3, 0);
    cyc(2);
    chk("cs_ok_err", {31'd0, checksum_err}, 32'd0);
    chk("cs_ok_done", {31'd0, load_done}, 32'd1);
    chk("cs_ok_count", word_count, 32'd2);
    pulse_go();
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'd4, 0);
    cyc(2);
    chk("cs_bad_err", {31'd0, checksum_err}, 32'd1);
    chk("cs_bad_done", {31'd0, load_done}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
